// File: rtl/stall_ctrl_pkg.sv
// stall_pkg: shared stall bus encoding, FSM states and stall patterns for the
// pipeline stall controller.
package stall_pkg;
    localparam int STALL_W = 6;
    typedef logic [STALL_W-1:0] stall_bus_t;
    localparam logic Stop = 1'b1;
    localparam logic NoStop = 1'b0;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_t;
    localparam stall_bus_t STALL_NONE = {STALL_W{NoStop}};
    localparam stall_bus_t STALL_MEM = {1'b0, {5{Stop}}};
    localparam stall_bus_t STALL_EX = {2'b00, {4{Stop}}};
    localparam stall_bus_t STALL_ID = {3'b000, {3{Stop}}};
endpackage

// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: stall request / StallBus bundle between the pipeline stages
// (master) and the stall controller (slave).
interface stall_ctrl_if #(parameter int MC_LEN_W = 6);
    import stall_pkg::*;
    logic flush;
    logic stallreq_id;
    logic ex_mc_start;
    logic [MC_LEN_W-1:0] ex_mc_len;
    logic stallreq_mem;
    stall_bus_t stall;
    logic mc_busy;
    logic mc_done;
    modport master(output flush, stallreq_id, ex_mc_start, ex_mc_len, stallreq_mem,
                   input stall, mc_busy, mc_done);
    modport slave(input flush, stallreq_id, ex_mc_start, ex_mc_len, stallreq_mem,
                  output stall, mc_busy, mc_done);
endinterface

// File: rtl/stall_ctrl_mc_counter.sv
// mc_counter: loadable down-counter for multi-cycle EX ops, with freeze
// (dec low) and a flag marking the final decrement.
module mc_counter #(parameter int W = 6) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    assign last = (cnt == W'(1));
endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: merges ID/EX/MEM stall requests into the StallBus and sequences
// multi-cycle EX operations.
module stall_ctrl
    import stall_pkg::*;
#(
    parameter int MC_LEN_W = 6
) (
    input logic        clk,
    input logic        resetn,
    stall_ctrl_if.slave bus
);
    mc_state_t state, nxt;
    logic busy_q, done_q, start_ok, cnt_last, ex_req;
    logic [MC_LEN_W-1:0] len_m1;
    assign start_ok = bus.ex_mc_start && state != BUSY && !bus.flush;
    assign len_m1 = (bus.ex_mc_len == '0) ? '0 : bus.ex_mc_len - 1'b1;
    mc_counter #(.W(MC_LEN_W)) u_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (bus.flush),
        .load     (start_ok),
        .load_val (len_m1),
        .dec      (state == BUSY && !bus.stallreq_mem),
        .last     (cnt_last)
    );
    // BUSY leaves on the cycle that performs the final decrement, so an
    // L-cycle op spends exactly L-1 cycles in BUSY.
    always_comb begin
        nxt = bus.flush ? IDLE :
              start_ok ? ((len_m1 == '0) ? DONE : BUSY) :
              (state == BUSY) ? ((!bus.stallreq_mem && cnt_last) ? DONE : BUSY) :
              IDLE;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= nxt;
            busy_q <= (nxt == BUSY);
            done_q <= (nxt == DONE);
        end
    assign ex_req = (bus.ex_mc_start && state != BUSY) || state == BUSY;
    always_comb begin
        bus.stall = (!resetn || bus.flush) ? STALL_NONE :
                    bus.stallreq_mem ? STALL_MEM :
                    ex_req ? STALL_EX :
                    bus.stallreq_id ? STALL_ID : STALL_NONE;
    end
    assign bus.mc_busy = busy_q;
    assign bus.mc_done = done_q && !bus.flush;
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed scoreboard bench for stall_ctrl; expected per-cycle
// outputs are queued as stimulus is driven and checked mid-cycle.
module tb_stall_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    localparam logic [5:0] N = 6'b000000;
    localparam logic [5:0] ID = 6'b000111;
    localparam logic [5:0] EX = 6'b001111;
    localparam logic [5:0] MEM = 6'b011111;

    stall_ctrl_if #(.MC_LEN_W(6)) bus ();
    stall_ctrl #(.MC_LEN_W(6)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    task automatic cyc(input logic rn, input logic fl, input logic id, input logic st,
                       input logic [5:0] len, input logic mem,
                       input logic [5:0] es, input logic eb, input logic ed, input string tag);
        logic [7:0] got, exp;
        resetn = rn;
        bus.flush = fl;
        bus.stallreq_id = id;
        bus.ex_mc_start = st;
        bus.ex_mc_len = len;
        bus.stallreq_mem = mem;
        exp_q.push_back({es, eb, ed});
        @(negedge clk);
        got = {bus.stall, bus.mc_busy, bus.mc_done};
        exp = exp_q.pop_front();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: stall/busy/done got %b_%b_%b expected %b_%b_%b",
                   tag, got[7:2], got[1], got[0], exp[7:2], exp[1], exp[0]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.flush = 0; bus.stallreq_id = 0; bus.ex_mc_start = 0;
        bus.ex_mc_len = 0; bus.stallreq_mem = 0;
        #1;
        cyc(0, 0, 0, 0, 0, 0, N, 0, 0, "reset");
        cyc(0, 0, 0, 1, 6'd3, 0, N, 0, 0, "reset_start_ignored");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 0, "idle");
        // load-use
        cyc(1, 0, 1, 0, 0, 0, ID, 0, 0, "load_use");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 0, "load_use_after");
        // length 5, with an ID request masked by the EX stall
        cyc(1, 0, 0, 1, 6'd5, 0, EX, 0, 0, "len5_start");
        cyc(1, 0, 1, 0, 0, 0, EX, 1, 0, "len5_busy1_id");
        for (int i = 2; i <= 4; i++) cyc(1, 0, 0, 0, 0, 0, EX, 1, 0, "len5_busy");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 1, "len5_done");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 0, "len5_idle");
        // MEM overlap, length 3
        cyc(1, 0, 0, 1, 6'd3, 0, EX, 0, 0, "mem_start");
        cyc(1, 0, 0, 0, 0, 0, EX, 1, 0, "mem_busy1");
        cyc(1, 0, 0, 0, 0, 1, MEM, 1, 0, "mem_freeze1");
        cyc(1, 0, 0, 0, 0, 1, MEM, 1, 0, "mem_freeze2");
        cyc(1, 0, 0, 0, 0, 0, EX, 1, 0, "mem_busy2");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 1, "mem_done");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 0, "mem_idle");
        // flush, length 8
        cyc(1, 0, 0, 1, 6'd8, 0, EX, 0, 0, "flush_start");
        cyc(1, 0, 0, 0, 0, 0, EX, 1, 0, "flush_busy");
        cyc(1, 1, 1, 0, 0, 1, N, 1, 0, "flush_cycle");
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 0, N, 0, 0, "flush_no_done");
        // edge lengths
        cyc(1, 0, 0, 1, 6'd0, 0, EX, 0, 0, "len0_start");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 1, "len0_done");
        cyc(1, 0, 0, 1, 6'd1, 0, EX, 0, 0, "len1_start");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 1, "len1_done");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 0, "len1_idle");
        // back-to-back length 2, with ID request in the final DONE
        cyc(1, 0, 0, 1, 6'd2, 0, EX, 0, 0, "b2b_start1");
        cyc(1, 0, 0, 0, 0, 0, EX, 1, 0, "b2b_busy1");
        cyc(1, 0, 0, 1, 6'd2, 0, EX, 0, 1, "b2b_done1_start2");
        cyc(1, 0, 0, 1, 6'd7, 0, EX, 1, 0, "b2b_busy2_start_ignored");
        cyc(1, 0, 1, 0, 0, 0, ID, 0, 1, "b2b_done2_id");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 0, "b2b_idle");
        // flush during DONE suppresses mc_done
        cyc(1, 0, 0, 1, 6'd1, 0, EX, 0, 0, "fdone_start");
        cyc(1, 1, 0, 0, 0, 0, N, 0, 0, "fdone_flush");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 0, "fdone_idle");
        // MEM outranks a start in IDLE; the op still launches
        cyc(1, 0, 0, 1, 6'd2, 1, MEM, 0, 0, "memstart_start");
        cyc(1, 0, 0, 0, 0, 0, EX, 1, 0, "memstart_busy");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 1, "memstart_done");
        // reset mid-BUSY, length 10
        cyc(1, 0, 0, 1, 6'd10, 0, EX, 0, 0, "rst_start");
        cyc(1, 0, 0, 0, 0, 0, EX, 1, 0, "rst_busy2");
        cyc(1, 0, 0, 0, 0, 0, EX, 1, 0, "rst_busy3");
        cyc(0, 0, 0, 0, 0, 0, N, 0, 0, "rst_async");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 0, "rst_release");
        cyc(1, 0, 0, 1, 6'd2, 0, EX, 0, 0, "rst_new_start");
        cyc(1, 0, 0, 0, 0, 0, EX, 1, 0, "rst_new_busy");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 1, "rst_new_done");
        cyc(1, 0, 0, 0, 0, 0, N, 0, 0, "rst_new_idle");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Central pipeline stall controller for the five-stage CPU core. It merges stall requests from ID (load-use), EX (multi-cycle ALU operations such as divide) and MEM (data SRAM wait) into the shared `StallBus` consumed by every pipeline register. It also sequences multi-cycle EX operations with an internal busy counter, so EX only raises a one-cycle start pulse. An exception/branch flush aborts any sequence in progress.

## Interface
- `MC_LEN_W`, default 6: width of the multi-cycle length field; maximum length is 2^MC_LEN_W − 1 cycles.
- `clk`  in  1  core clock; all state updates on its rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  pipeline flush; aborts the multi-cycle sequence and suppresses all stalls this cycle.
- `stallreq_id`  in  1  ID load-use hazard request, combinational, level.
- `ex_mc_start`  in  1  EX starts a multi-cycle op; single-cycle pulse.
- `ex_mc_len`  in  MC_LEN_W  op length in cycles, sampled with `ex_mc_start`.
- `stallreq_mem`  in  1  MEM waiting on data SRAM, level.
- `stall`  out  `StallBus` (6)  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = `Stop`.
- `mc_busy`  out  1  multi-cycle sequence in progress.
- `mc_done`  out  1  one-cycle pulse: EX result valid, EX may advance.

## Operation
- FSM states: IDLE, BUSY, DONE (encoded in the shared package).
- IDLE: on `ex_mc_start` with `flush` low, load `cnt` = max(ex_mc_len, 1) − 1. If the loaded value is 0, go to DONE; otherwise go to BUSY.
- BUSY: decrement `cnt` each cycle that `stallreq_mem` is low; freeze while high. At `cnt`==0 with `stallreq_mem` low, go to DONE.
- DONE: assert `mc_done` for one cycle, then go to IDLE. `ex_mc_start` in DONE is treated as a start from IDLE: a back-to-back op reloads and goes to BUSY/DONE as in IDLE.
- `ex_mc_start` while in BUSY is ignored.
- `flush` high in any state: next state IDLE, `cnt` ← 0, and no `mc_done`.
- Stall priority, combinational, highest first:
  - `flush` → `stall` = 6'b000000.
  - `stallreq_mem` → 6'b011111.
  - EX request (`ex_mc_start` in IDLE/DONE, or state BUSY) → 6'b001111.
  - `stallreq_id` → 6'b000111.
  - Otherwise 6'b000000.
- In DONE, EX is not stalled. `stallreq_id` in DONE still yields 6'b000111.
- `mc_busy` = (state == BUSY).
- Reset: state IDLE, `cnt` 0, `stall` 0, `mc_busy` 0, `mc_done` 0.

## Timing
- `stall` is combinational from inputs and state; there is no register on `stall`.
- A length-L op (L ≥ 2) with no MEM stalls gives `stall[3]` high for L cycles: the start cycle plus L−1 BUSY cycles. `mc_done` is high in cycle L+1 (DONE), and EX advances at the end of that cycle.
- L = 0 or 1: the start cycle stalls EX once, and the following cycle is DONE.
- Every cycle with `stallreq_mem` high extends the sequence by one cycle.
- Reset deassertion is synchronised externally; the FSM leaves IDLE no earlier than the first edge after `resetn` rises.
- Asserting `resetn` low mid-sequence immediately forces all outputs to their reset values.

## Structure
- Shared package `stall_pkg`:
  - `StallBus` width (6) and `Stop`/`NoStop` constants.
  - FSM state typedef.
  - Stall pattern constants STALL_MEM, STALL_EX, STALL_ID.
- Optional sub-module `mc_counter`: the loadable down-counter with freeze input and zero flag. The rest stays flat.

## Test plan
- Reset mid-BUSY: length 10, pull `resetn` low at cycle 4 → `stall`=0, `mc_busy`=0 in the same cycle. After release, a new start behaves normally.
- Load-use: `stallreq_id` high for 1 cycle, nothing else → `stall`=6'b000111 for exactly that cycle, and the FSM stays IDLE.
- Length 5: `ex_mc_start` with `ex_mc_len`=5 → `stall`=6'b001111 for 5 cycles, `mc_done` high on cycle 6 with `stall`=0, then IDLE.
- MEM overlap: length 3, `stallreq_mem` high for 2 cycles mid-BUSY → `stall`=6'b011111 for those 2 cycles. `mc_done` is delayed by 2 cycles, at cycle 6.
- Flush: length 8, `flush` at cycle 3 → `stall`=0 that cycle, IDLE next cycle, and `mc_done` never asserts.
- Edge lengths and back-to-back:
  - `ex_mc_len`=0 and =1 → one EX stall cycle, then `mc_done`.
  - `ex_mc_start` in DONE with length 2 → `mc_done` pulses twice, with no idle gap before the second op's stall.
